// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer and its users.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } reset_seq_state_t;

    localparam int SOFT_COUNT_W = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync_n.sv
// Active-low reset synchronizer: asynchronous assertion, release after SYNC_STAGES clocks.
module reset_sync_n #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_n_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    // Shift chain cleared asynchronously, filled with ones after release.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            chain_q <= {SYNC_STAGES{1'b0}};
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Root reset sequencer: hold all stage resets, then release them in index order.
// Optional saturating soft-reset counter enabled by the RESET_SEQ_COUNT_EN macro.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES        = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int STAGE_GAP         = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    soft_req,
    output logic                    soft_ack,
    output logic [NUM_STAGES-1:0]   reset_out,
    output logic                    done
`ifdef RESET_SEQ_COUNT_EN
    ,
    output logic [SOFT_COUNT_W-1:0] soft_count
`endif
);

    localparam int CNT_W = $clog2(max_int(MIN_ASSERT_CYCLES, STAGE_GAP) + 1);
    localparam int IDX_W = $clog2(NUM_STAGES) + 1;

    reset_seq_state_t       state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   soft_pending_q, soft_pending_d;
    logic                   soft_req_q;
    logic [NUM_STAGES-1:0]  reset_out_q, reset_out_d;
    logic                   done_q, done_d;
    logic                   soft_ack_q, soft_ack_d;
    logic                   sync_s;
    logic                   soft_rise_s;

    reset_sync_n #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync_n (
        .clk_i    (clk),
        .arst_n_i (reset_n),
        .sync_o   (sync_s)
    );

    assign soft_rise_s = soft_req & ~soft_req_q;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        soft_pending_d = soft_pending_q;
        reset_out_d    = {NUM_STAGES{1'b1}};
        done_d         = 1'b0;
        soft_ack_d     = 1'b0;

        case (state_q)
            SYNC: begin
                if (sync_s) begin
                    state_d = HOLD;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = SYNC;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(MIN_ASSERT_CYCLES - 1)) begin
                    state_d = RELEASE;
                    idx_d   = {IDX_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (soft_rise_s) begin
                    state_d        = HOLD;
                    cnt_d          = {CNT_W{1'b0}};
                    soft_pending_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        // Ack only on the entry into DONE that completes a soft request.
        if ((state_d == DONE) && (state_q != DONE) && soft_pending_q) begin
            soft_ack_d     = 1'b1;
            soft_pending_d = 1'b0;
        end else begin
            soft_ack_d = 1'b0;
        end

        if (state_d == DONE) begin
            done_d      = 1'b1;
            reset_out_d = {NUM_STAGES{1'b0}};
        end else if (state_d == RELEASE) begin
            done_d = 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (IDX_W'(i) <= idx_d) begin
                    reset_out_d[i] = 1'b0;
                end else begin
                    reset_out_d[i] = 1'b1;
                end
            end
        end else begin
            done_d      = 1'b0;
            reset_out_d = {NUM_STAGES{1'b1}};
        end
    end

    // State and output registers; reset_n forces every stage reset immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= SYNC;
            cnt_q          <= {CNT_W{1'b0}};
            idx_q          <= {IDX_W{1'b0}};
            soft_pending_q <= 1'b0;
            soft_req_q     <= 1'b0;
            reset_out_q    <= {NUM_STAGES{1'b1}};
            done_q         <= 1'b0;
            soft_ack_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            soft_pending_q <= soft_pending_d;
            soft_req_q     <= soft_req;
            reset_out_q    <= reset_out_d;
            done_q         <= done_d;
            soft_ack_q     <= soft_ack_d;
        end
    end

    assign reset_out = reset_out_q;
    assign done      = done_q;
    assign soft_ack  = soft_ack_q;

`ifdef RESET_SEQ_COUNT_EN
    logic [SOFT_COUNT_W-1:0] soft_count_q;

    // Saturating count of completed soft sequences, cleared only by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            soft_count_q <= {SOFT_COUNT_W{1'b0}};
        end else if (soft_ack_d && (soft_count_q != {SOFT_COUNT_W{1'b1}})) begin
            soft_count_q <= soft_count_q + SOFT_COUNT_W'(1);
        end else begin
            soft_count_q <= soft_count_q;
        end
    end

    assign soft_count = soft_count_q;
`endif

endmodule
